// File: rtl/ft245_fifo_bridge.sv
// FT232H 245-style async FIFO bus to RX/TX byte streams with FWFT buffering and RX/TX round-robin.
// Latency: RX byte RD_PULSE+RECOVER+SYNC_STAGES+1 cycles, TX byte WR_SETUP+WR_PULSE+RECOVER+SYNC_STAGES+1.
// Backpressure: full RX FIFO withholds RD# (RXF# stays pending); tx_ready drops when TX FIFO is full.
module ft245_fifo_bridge #(
    parameter int SYNC_STAGES = 2,
    parameter int RD_PULSE    = 4,
    parameter int WR_SETUP    = 1,
    parameter int WR_PULSE    = 2,
    parameter int RECOVER     = 1,
    parameter int RX_DEPTH    = 16,
    parameter int TX_DEPTH    = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    inout  wire  [7:0]                FT_ADBUS,
    inout  wire  [6:0]                FT_ACBUS,
    output logic [7:0]                rx_data,
    output logic                      rx_valid,
    input  logic                      rx_ready,
    input  logic [7:0]                tx_data,
    input  logic                      tx_valid,
    output logic                      tx_ready,
    output logic [$clog2(RX_DEPTH):0] rx_count,
    output logic [$clog2(TX_DEPTH):0] tx_count
);
    localparam int RXAW = $clog2(RX_DEPTH);
    localparam int TXAW = $clog2(TX_DEPTH);
    localparam int RXCW = RXAW + 1;
    localparam int TXCW = TXAW + 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RD_LOW = 3'd1;
    localparam logic [2:0] S_WR_SET = 3'd2;
    localparam logic [2:0] S_WR_LOW = 3'd3;
    localparam logic [2:0] S_GAP    = 3'd4;

    localparam logic [15:0] RD_LAST    = 16'(RD_PULSE - 1);
    localparam logic [15:0] SETUP_LAST = 16'(WR_SETUP - 1);
    localparam logic [15:0] WR_LAST    = 16'(WR_PULSE - 1);
    localparam logic [15:0] GAP_LAST   = 16'(RECOVER + SYNC_STAGES - 1);

    logic [2:0]             state;
    logic [15:0]            cnt;
    logic                   rd_n;
    logic                   wr_n;
    logic                   ad_oe;
    logic [7:0]             out_reg;
    logic                   prio_rx;
    logic [SYNC_STAGES-1:0] rxf_sync;
    logic [SYNC_STAGES-1:0] txe_sync;
    logic                   rxf_s;
    logic                   txe_s;

    logic                   in_idle;
    logic                   rx_req;
    logic                   tx_req;
    logic                   serve_rx;
    logic                   serve_tx;
    logic                   rx_push;
    logic                   tx_pop;

    // RX FIFO state
    logic [7:0]             rx_mem [RX_DEPTH];
    logic [RXAW-1:0]        rx_wr_ptr;
    logic [RXAW-1:0]        rx_rd_ptr;
    logic [RXAW:0]          rx_count_nxt;
    logic                   rx_space;
    logic                   rx_push_en;
    logic                   rx_pop;

    // TX FIFO state
    logic [7:0]             tx_mem [TX_DEPTH];
    logic [TXAW-1:0]        tx_wr_ptr;
    logic [TXAW-1:0]        tx_rd_ptr;
    logic [TXAW:0]          tx_count_nxt;
    logic                   tx_head_vld;
    logic                   tx_push;
    logic [7:0]             tx_head;

    assign FT_ADBUS      = ad_oe ? out_reg : 8'hzz;
    assign FT_ACBUS[2]   = rd_n;
    assign FT_ACBUS[3]   = wr_n;
    assign FT_ACBUS[6:4] = 3'bzzz;

    always_ff @(posedge clock) begin
        if (reset) begin
            rxf_sync <= '1;
            txe_sync <= '1;
        end else begin
            rxf_sync <= {rxf_sync[SYNC_STAGES-2:0], FT_ACBUS[0]};
            txe_sync <= {txe_sync[SYNC_STAGES-2:0], FT_ACBUS[1]};
        end
    end

    assign rxf_s = rxf_sync[SYNC_STAGES-1];
    assign txe_s = txe_sync[SYNC_STAGES-1];

    // rx_space and tx_head_vld are the registered "count<DEPTH" and "count!=0" flags
    assign in_idle  = (state == S_IDLE);
    assign rx_req   = !rxf_s && rx_space;
    assign tx_req   = !txe_s && tx_head_vld;
    assign serve_rx = in_idle && rx_req && (prio_rx || !tx_req);
    assign serve_tx = in_idle && tx_req && !serve_rx;
    assign tx_pop   = serve_tx;
    assign rx_push  = (state == S_RD_LOW) && (cnt == RD_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            rd_n    <= 1'b1;
            wr_n    <= 1'b1;
            ad_oe   <= 1'b0;
            out_reg <= '0;
            prio_rx <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (serve_rx) begin
                        state   <= S_RD_LOW;
                        rd_n    <= 1'b0;
                        prio_rx <= 1'b0;
                    end else if (serve_tx) begin
                        state   <= S_WR_SET;
                        ad_oe   <= 1'b1;
                        out_reg <= tx_head;
                        prio_rx <= 1'b1;
                    end
                end
                S_RD_LOW: begin
                    if (cnt == RD_LAST) begin
                        rd_n  <= 1'b1;
                        state <= S_GAP;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_WR_SET: begin
                    if (cnt == SETUP_LAST) begin
                        wr_n  <= 1'b0;
                        state <= S_WR_LOW;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_WR_LOW: begin
                    if (cnt == WR_LAST) begin
                        wr_n  <= 1'b1;
                        ad_oe <= 1'b0;
                        state <= S_GAP;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_GAP: begin
                    // both strobes high long enough for the synchronisers to flush stale flags
                    if (cnt == GAP_LAST) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                    rd_n  <= 1'b1;
                    wr_n  <= 1'b1;
                    ad_oe <= 1'b0;
                end
            endcase
        end
    end

    assign rx_push_en = rx_push && rx_space;
    assign rx_pop     = rx_valid && rx_ready;
    assign rx_data    = rx_valid ? rx_mem[rx_rd_ptr] : 8'h00;

    always_comb begin
        rx_count_nxt = rx_count;
        if (rx_push_en && !rx_pop) begin
            rx_count_nxt = rx_count + RXCW'(1);
        end else if (rx_pop && !rx_push_en) begin
            rx_count_nxt = rx_count - RXCW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_count  <= '0;
            rx_valid  <= 1'b0;
            rx_space  <= 1'b0;
        end else begin
            if (rx_push_en) begin
                rx_wr_ptr <= rx_wr_ptr + RXAW'(1);
            end
            if (rx_pop) begin
                rx_rd_ptr <= rx_rd_ptr + RXAW'(1);
            end
            rx_count <= rx_count_nxt;
            rx_valid <= (rx_count_nxt != '0);
            rx_space <= (rx_count_nxt != RXCW'(RX_DEPTH));
        end
    end

    always_ff @(posedge clock) begin
        if (rx_push_en) begin
            rx_mem[rx_wr_ptr] <= FT_ADBUS;
        end
    end

    assign tx_push = tx_valid && tx_ready;
    assign tx_head = tx_mem[tx_rd_ptr];

    always_comb begin
        tx_count_nxt = tx_count;
        if (tx_push && !tx_pop) begin
            tx_count_nxt = tx_count + TXCW'(1);
        end else if (tx_pop && !tx_push) begin
            tx_count_nxt = tx_count - TXCW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tx_wr_ptr   <= '0;
            tx_rd_ptr   <= '0;
            tx_count    <= '0;
            tx_ready    <= 1'b0;
            tx_head_vld <= 1'b0;
        end else begin
            if (tx_push) begin
                tx_wr_ptr <= tx_wr_ptr + TXAW'(1);
            end
            if (tx_pop) begin
                tx_rd_ptr <= tx_rd_ptr + TXAW'(1);
            end
            tx_count    <= tx_count_nxt;
            tx_ready    <= (tx_count_nxt != TXCW'(TX_DEPTH));
            tx_head_vld <= (tx_count_nxt != '0);
        end
    end

    always_ff @(posedge clock) begin
        if (tx_push) begin
            tx_mem[tx_wr_ptr] <= tx_data;
        end
    end

endmodule

// File: tb/tb_ft245_fifo_bridge.sv
// Bench for ft245_fifo_bridge: FT232H host model on the pins, byte queues as the reference.
module tb_ft245_fifo_bridge;
    localparam int SYNC_STAGES = 2;
    localparam int RD_PULSE    = 4;
    localparam int WR_SETUP    = 1;
    localparam int WR_PULSE    = 2;
    localparam int RECOVER     = 1;
    localparam int RX_DEPTH    = 16;
    localparam int TX_DEPTH    = 16;
    localparam int GAP_MIN     = RECOVER + SYNC_STAGES;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    wire  [7:0] ft_adbus;
    wire  [6:0] ft_acbus;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [4:0] rx_count;
    logic [4:0] tx_count;

    int checks = 0;
    int errors = 0;

    logic       host_rxf_n = 1'b1;
    logic       host_txe_n = 1'b1;
    logic [7:0] host_head = 8'h00;
    logic       host_prev_rd = 1'b1;
    logic       hold_rx = 1'b0;
    logic       hold_tx = 1'b1;
    logic       mon_en = 1'b0;

    logic [7:0] host_q[$];
    logic [7:0] got_q[$];
    logic [7:0] sink_q[$];
    logic [7:0] seq_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] txexp_q[$];

    int rd_pulses = 0;
    int wr_pulses = 0;

    always #5 clock = ~clock;

    assign ft_acbus[0] = host_rxf_n;
    assign ft_acbus[1] = host_txe_n;
    assign ft_adbus    = (ft_acbus[2] == 1'b0) ? host_head : 8'hzz;

    ft245_fifo_bridge #(
        .SYNC_STAGES(SYNC_STAGES), .RD_PULSE(RD_PULSE), .WR_SETUP(WR_SETUP),
        .WR_PULSE(WR_PULSE), .RECOVER(RECOVER), .RX_DEPTH(RX_DEPTH), .TX_DEPTH(TX_DEPTH)
    ) dut (
        .clock(clock), .reset(reset), .FT_ADBUS(ft_adbus), .FT_ACBUS(ft_acbus),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_count(rx_count), .tx_count(tx_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_tx(input logic [7:0] b);
        logic ok;
        ok = 1'b0;
        tx_data  = b;
        tx_valid = 1'b1;
        for (int i = 0; i < 500 && !ok; i++) begin
            ok = tx_ready;
            tick();
        end
        tx_valid = 1'b0;
        check("push_tx_accept", ok, 1);
    endtask

    // Host side of the FT232H: RXF# low while bytes are queued, byte consumed when RD# rises.
    always @(negedge clock) begin
        if (host_prev_rd == 1'b0 && ft_acbus[2] == 1'b1 && host_q.size() != 0)
            void'(host_q.pop_front());
        host_prev_rd = ft_acbus[2];
        host_rxf_n   = hold_rx || (host_q.size() == 0);
        host_txe_n   = hold_tx;
        host_head    = (host_q.size() != 0) ? host_q[0] : 8'h00;
    end

    always @(negedge clock) begin
        if (rx_valid && rx_ready) got_q.push_back(rx_data);
    end

    logic       m_rd, m_wr, m_oe;
    logic       prev_rd = 1'b1, prev_wr = 1'b1, prev_oe = 1'b0, have_strobe = 1'b0;
    logic [7:0] hold_dat = 8'h00;
    int         rd_len = 0, wr_len = 0, gap_len = 0, setup_len = 0;

    always @(negedge clock) begin
        if (!mon_en) begin
            prev_rd = 1'b1; prev_wr = 1'b1; prev_oe = 1'b0; have_strobe = 1'b0;
            rd_len = 0; wr_len = 0; gap_len = 0; setup_len = 0;
        end else begin
            m_rd = ft_acbus[2];
            m_wr = ft_acbus[3];
            m_oe = dut.ad_oe;
            check("no_contention", {30'd0, !m_rd && m_oe, !m_rd && !m_wr}, 0);
            if ((prev_rd && !m_rd) || (prev_wr && !m_wr)) begin
                if (have_strobe) check("strobe_gap", gap_len >= GAP_MIN, 1);
                seq_q.push_back(!m_rd ? 8'h52 : 8'h57);
                have_strobe = 1'b1;
                gap_len = 0;
            end
            if (m_rd && m_wr) gap_len++;
            if (!m_rd) rd_len++;
            if (!prev_rd && m_rd) begin
                check("rd_pulse_len", rd_len, RD_PULSE);
                rd_len = 0;
                rd_pulses++;
            end
            if (m_oe && m_wr) setup_len++;
            if (m_oe) begin
                if (!prev_oe) hold_dat = ft_adbus;
                else check("adbus_stable", ft_adbus, hold_dat);
            end else begin
                setup_len = 0;
            end
            if (prev_wr && !m_wr) begin
                check("wr_setup", setup_len >= WR_SETUP, 1);
                sink_q.push_back(ft_adbus);
            end
            if (!m_wr) wr_len++;
            if (!prev_wr && m_wr) begin
                check("wr_pulse_len", wr_len, WR_PULSE);
                wr_len = 0;
                wr_pulses++;
            end
            prev_rd = m_rd;
            prev_wr = m_wr;
            prev_oe = m_oe;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int p0;
        logic [7:0] b;

        // 1: reset and idle pins
        repeat (3) tick();
        check("rst_rd_n", ft_acbus[2], 1);
        check("rst_wr_n", ft_acbus[3], 1);
        check("rst_ad_oe", dut.ad_oe, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_tx_ready", tx_ready, 0);
        check("rst_rx_count", rx_count, 0);
        check("rst_tx_count", tx_count, 0);
        reset  = 1'b0;
        mon_en = 1'b1;
        repeat (2) tick();
        check("idle_tx_ready", tx_ready, 1);
        check("idle_rx_valid", rx_valid, 0);
        check("idle_rx_count", rx_count, 0);
        check("idle_tx_count", tx_count, 0);
        check("idle_rd_n", ft_acbus[2], 1);
        check("idle_wr_n", ft_acbus[3], 1);

        // 2: two host bytes
        rx_ready = 1'b1;
        p0 = rd_pulses;
        host_q.push_back(8'hA5);
        host_q.push_back(8'h3C);
        for (int i = 0; i < 300 && got_q.size() < 2; i++) tick();
        repeat (2) tick();
        check("t2_rx_bytes", got_q.size(), 2);
        check("t2_byte0", got_q[0], 8'hA5);
        check("t2_byte1", got_q[1], 8'h3C);
        check("t2_rd_pulses", rd_pulses - p0, 2);

        // 3: sixteen TX bytes
        sink_q.delete();
        p0 = wr_pulses;
        hold_tx = 1'b0;
        for (int k = 1; k <= 16; k++) push_tx(8'(k));
        for (int i = 0; i < 600 && sink_q.size() < 16; i++) tick();
        repeat (5) tick();
        check("t3_tx_bytes", sink_q.size(), 16);
        for (int i = 0; i < 16; i++) check("t3_tx_byte", sink_q[i], 32'(i + 1));
        check("t3_tx_count", tx_count, 0);
        check("t3_wr_pulses", wr_pulses - p0, 16);
        hold_tx = 1'b1;

        // 4: RX backpressure
        rx_ready = 1'b0;
        got_q.delete();
        exp_q.delete();
        for (int i = 0; i < 20; i++) begin
            b = 8'($urandom);
            host_q.push_back(b);
            exp_q.push_back(b);
        end
        for (int i = 0; i < 600 && rx_count != 5'd16; i++) tick();
        check("t4_rx_full", rx_count, RX_DEPTH);
        repeat (2) tick();
        p0 = rd_pulses;
        repeat (40) tick();
        check("t4_rx_hold", rx_count, RX_DEPTH);
        check("t4_no_rd", rd_pulses - p0, 0);
        check("t4_rd_high", ft_acbus[2], 1);
        check("t4_host_pending", host_q.size(), 4);
        check("t4_rx_valid", rx_valid, 1);
        check("t4_rx_head", rx_data, exp_q[0]);
        rx_ready = 1'b1;
        for (int i = 0; i < 600 && got_q.size() < 20; i++) tick();
        check("t4_rx_bytes", got_q.size(), 20);
        for (int i = 0; i < 20; i++) check("t4_rx_byte", got_q[i], exp_q[i]);

        // 5: RX and TX both pending
        hold_rx = 1'b1;
        hold_tx = 1'b1;
        got_q.delete();
        exp_q.delete();
        txexp_q.delete();
        sink_q.delete();
        for (int i = 0; i < 8; i++) begin
            b = 8'($urandom);
            host_q.push_back(b);
            exp_q.push_back(b);
            b = 8'($urandom);
            txexp_q.push_back(b);
            push_tx(b);
        end
        repeat (2) tick();
        seq_q.delete();
        hold_rx = 1'b0;
        hold_tx = 1'b0;
        for (int i = 0; i < 800 && (got_q.size() < 8 || sink_q.size() < 8); i++) tick();
        repeat (5) tick();
        check("t5_rx_bytes", got_q.size(), 8);
        check("t5_tx_bytes", sink_q.size(), 8);
        check("t5_strobes", seq_q.size(), 16);
        for (int i = 1; i < 16; i++) check("t5_alternate", seq_q[i] != seq_q[i-1], 1);
        for (int i = 0; i < 8; i++) begin
            check("t5_rx_byte", got_q[i], exp_q[i]);
            check("t5_tx_byte", sink_q[i], txexp_q[i]);
        end
        check("t5_tx_count", tx_count, 0);
        hold_tx = 1'b1;

        // 6a: reset during RD_LOW
        rx_ready = 1'b0;
        for (int i = 0; i < 3; i++) host_q.push_back(8'($urandom));
        for (int i = 0; i < 100 && ft_acbus[2] != 1'b0; i++) tick();
        check("t6_rd_low_seen", ft_acbus[2], 0);
        tick();
        mon_en = 1'b0;
        reset  = 1'b1;
        tick();
        check("t6a_rd_n", ft_acbus[2], 1);
        check("t6a_wr_n", ft_acbus[3], 1);
        check("t6a_ad_oe", dut.ad_oe, 0);
        check("t6a_rx_count", rx_count, 0);
        check("t6a_rx_valid", rx_valid, 0);
        check("t6a_tx_ready", tx_ready, 0);
        hold_rx = 1'b1;
        tick();
        host_q.delete();
        repeat (2) tick();
        reset = 1'b0;
        repeat (2) tick();
        check("t6a_post_rx_count", rx_count, 0);
        check("t6a_post_rx_valid", rx_valid, 0);

        // 6b: reset during WR_LOW
        mon_en = 1'b1;
        for (int i = 0; i < 3; i++) push_tx(8'($urandom));
        hold_tx = 1'b0;
        for (int i = 0; i < 100 && ft_acbus[3] != 1'b0; i++) tick();
        check("t6_wr_low_seen", ft_acbus[3], 0);
        mon_en = 1'b0;
        reset  = 1'b1;
        tick();
        check("t6b_wr_n", ft_acbus[3], 1);
        check("t6b_rd_n", ft_acbus[2], 1);
        check("t6b_ad_oe", dut.ad_oe, 0);
        check("t6b_tx_count", tx_count, 0);
        check("t6b_tx_ready", tx_ready, 0);
        hold_tx = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        repeat (2) tick();
        check("t6b_post_tx_count", tx_count, 0);
        check("t6b_post_rx_count", rx_count, 0);
        check("t6b_post_tx_ready", tx_ready, 1);
        check("t6b_post_ad_oe", dut.ad_oe, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
